// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the RAM-backed synchronous FIFO.
package sync_fifo_pkg;

  // Occupancy of the 2-entry prefetch stage (output register plus skid register).
  typedef logic [1:0] pf_cnt_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flag values for an empty FIFO; used by both reset and flush.
  localparam fifo_flags_t FlagsEmpty = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Single-clock simple-dual-port RAM with registered read data.
module ram_sdp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port and 1-cycle-latency read port; data is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FWFT FIFO: inferred SDP RAM followed by a 2-entry prefetch stage.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned ALMOST_FULL  = 28,
  parameter int unsigned ALMOST_EMPTY = 4,
  parameter string       INIT_FILE    = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH:0]   used_words_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int unsigned      DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam int unsigned      CntW     = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]  DepthCnt = DEPTH[CntW-1:0];
  localparam logic [CntW-1:0]  AfCnt    = ALMOST_FULL[CntW-1:0];
  localparam logic [CntW-1:0]  AeCnt    = ALMOST_EMPTY[CntW-1:0];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       ram_cnt_q, ram_cnt_d, used_q, used_d;
  logic                  inflight_q, inflight_d;
  pf_cnt_t               pf_q, pf_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  fifo_flags_t           flags_q, flags_d;

  logic                  push, pop, ram_rd, land;
  logic [2:0]            demand;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Handshakes and RAM read issue. The pending pop is netted out of the demand so
  // a read can be issued every cycle while streaming.
  always_comb begin
    push   = wr_valid_i & ~flags_q.full;
    pop    = (pf_q != '0) & rd_ready_i;
    demand = {1'b0, pf_q} + {2'b00, inflight_q} - {2'b00, pop};
    ram_rd = (ram_cnt_q != '0) && (demand < 3'd2);
    land   = inflight_q;
  end

  ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_i      (push & ~flush_i),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_i      (ram_rd & ~flush_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  // Next-state: pointers, counts, prefetch steering and registered flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    used_d     = used_q;
    inflight_d = inflight_q;
    pf_d       = pf_q;
    out_d      = out_q;
    skid_d     = skid_q;
    flags_d    = flags_q;

    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      used_d     = '0;
      inflight_d = 1'b0;
      pf_d       = '0;
      out_d      = '0;
      flags_d    = FlagsEmpty;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (ram_rd) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_d  = ram_cnt_q + CntW'(push) - CntW'(ram_rd);
      used_d     = used_q + CntW'(push) - CntW'(pop);
      inflight_d = ram_rd;

      // Skid word moves forward when the head is taken with both entries full.
      if (pop && pf_q == 2'd2) out_d = skid_q;
      if (land) begin
        if (pf_q == 2'd0 || (pop && pf_q == 2'd1)) out_d = ram_rdata;
        else skid_d = ram_rdata;
      end
      pf_d = pf_q + pf_cnt_t'(land) - pf_cnt_t'(pop);

      flags_d.full         = (used_d == DepthCnt);
      flags_d.empty        = (used_d == '0);
      flags_d.almost_full  = (used_d >= AfCnt);
      flags_d.almost_empty = (used_d <= AeCnt);
    end
  end

  // State registers with asynchronous active-low reset; skid data needs no reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      used_q     <= '0;
      inflight_q <= 1'b0;
      pf_q       <= '0;
      out_q      <= '0;
      flags_q    <= FlagsEmpty;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      used_q     <= used_d;
      inflight_q <= inflight_d;
      pf_q       <= pf_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
    end
  end

  // Skid register holds data only while pf_q == 2.
  always_ff @(posedge clk_i) begin
    skid_q <= skid_d;
  end

  assign wr_ready_o     = ~flags_q.full;
  assign rd_data_o      = out_q;
  assign rd_valid_o     = (pf_q != '0);
  assign used_words_o   = used_q;
  assign full_o         = flags_q.full;
  assign empty_o        = flags_q.empty;
  assign almost_full_o  = flags_q.almost_full;
  assign almost_empty_o = flags_q.almost_empty;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Scoreboard bench for sync_fifo_ram: pushes are recorded, a monitor checks every head word.
module tb_sync_fifo_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       rd_ready = 1'b0;

  logic       wr_ready_o, rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [7:0] rd_data_o;
  logic [5:0] used_words_o;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pops = 0;
  logic [7:0] exp_q[$];

  sync_fifo_ram #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (5),
    .ALMOST_FULL  (28),
    .ALMOST_EMPTY (4),
    .INIT_FILE    ("")
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .flush_i        (flush),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready_o),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready),
    .used_words_o   (used_words_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees exactly what the next edge will sample.
  always @(negedge clk) begin
    if (rd_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_data: got 0x%0h, want no valid word (scoreboard empty)", rd_data_o);
      end else begin
        check("rd_data", 32'(rd_data_o), 32'(exp_q[0]));
        if (rd_ready && !flush) begin
          void'(exp_q.pop_front());
          n_pops++;
        end
      end
    end
    if (wr_valid && wr_ready_o && !flush && rst_n) exp_q.push_back(wr_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int p0, input int want_pops, input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 300 && (rd_valid_o || used_words_o != '0); i++) step();
    rd_ready = 1'b0;
    check({tag, " used after drain"}, 32'(used_words_o), 0);
    check({tag, " empty after drain"}, 32'(empty_o), 1);
    check({tag, " pop count"}, 32'(n_pops - p0), 32'(want_pops));
  endtask

  initial begin
    int         p0;
    int         sent;
    logic       acc;
    logic [15:0] pat;

    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("reset used", 32'(used_words_o), 0);
    check("reset empty", 32'(empty_o), 1);
    check("reset almost_empty", 32'(almost_empty_o), 1);
    check("reset full", 32'(full_o), 0);
    check("reset almost_full", 32'(almost_full_o), 0);
    check("reset wr_ready", 32'(wr_ready_o), 1);
    check("reset rd_valid", 32'(rd_valid_o), 0);
    check("reset rd_data", 32'(rd_data_o), 0);

    // Ordering: five words with the consumer stalled; valid appears two edges after the first push
    p0 = n_pops;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(i + 1);
      step();
      check("order rd_valid latency", 32'(rd_valid_o), (i >= 2) ? 1 : 0);
    end
    wr_valid = 1'b0;
    check("order used 5", 32'(used_words_o), 5);
    check("order almost_empty at 5", 32'(almost_empty_o), 0);
    drain(p0, 5, "order");
    // Pop on an empty FIFO has no effect; head keeps the last word
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("empty pop used", 32'(used_words_o), 0);
    check("last word held", 32'(rd_data_o), 32'h05);

    // Fill to DEPTH with flag tracking, then an overflow attempt
    p0 = n_pops;
    wr_valid = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      wr_data = 8'(k - 1);
      step();
      check("fill used", 32'(used_words_o), 32'(k));
      check("fill almost_full", 32'(almost_full_o), (k >= 28) ? 1 : 0);
      check("fill almost_empty", 32'(almost_empty_o), (k <= 4) ? 1 : 0);
    end
    check("fill full", 32'(full_o), 1);
    check("fill wr_ready", 32'(wr_ready_o), 0);
    wr_data = 8'hEE;
    step();
    wr_valid = 1'b0;
    check("overflow used", 32'(used_words_o), 32);
    drain(p0, 32, "fill");

    // Streaming: one word per clock once the two-cycle fill is done
    p0 = n_pops;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wr_data = 8'(c);
      step();
      if (c >= 2) begin
        check("stream rd_valid", 32'(rd_valid_o), 1);
        check("stream used", 32'(used_words_o), 3);
      end
    end
    wr_valid = 1'b0;
    drain(p0, 100, "stream");

    // Backpressure with a sparse ready pattern; scoreboard also checks stalled data
    p0 = n_pops;
    sent = 0;
    pat = 16'b1000_1001_0010_0100;
    wr_valid = 1'b1;
    for (int c = 0; c < 1000 && sent < 60; c++) begin
      wr_data = 8'(32'h80 + sent);
      rd_ready = pat[c % 16];
      acc = wr_ready_o;
      step();
      if (acc) sent++;
    end
    wr_valid = 1'b0;
    check("bp words accepted", 32'(sent), 60);
    drain(p0, 60, "bp");

    // Flush with a simultaneous push: flush wins
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(32'h10 + i);
      step();
    end
    check("pre-flush used", 32'(used_words_o), 10);
    flush = 1'b1;
    wr_data = 8'h55;
    step();
    flush = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    check("flush used", 32'(used_words_o), 0);
    check("flush rd_valid", 32'(rd_valid_o), 0);
    check("flush empty", 32'(empty_o), 1);
    check("flush rd_data", 32'(rd_data_o), 0);
    check("flush wr_ready", 32'(wr_ready_o), 1);
    step();
    check("flush dropped push", 32'(used_words_o), 0);
    p0 = n_pops;
    wr_valid = 1'b1;
    wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    drain(p0, 1, "post-flush");

    // Asynchronous reset mid-cycle
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(32'h30 + i);
      step();
    end
    wr_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async rst used", 32'(used_words_o), 0);
    check("async rst rd_valid", 32'(rd_valid_o), 0);
    check("async rst empty", 32'(empty_o), 1);
    check("async rst rd_data", 32'(rd_data_o), 0);
    check("async rst almost_empty", 32'(almost_empty_o), 1);
    step();
    rst_n = 1'b1;
    step();
    p0 = n_pops;
    wr_valid = 1'b1;
    wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    drain(p0, 1, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
